wb_decoder_n: RTL and testbench
===============================

# wb_decoder_n

Parametrised Wishbone B4 classic single-master, N-slave address decoder replacing the fixed four-way CPU bus mux. Sits between the CPU master port and the SoC peripherals (RAM, timer, UART, future slaves), with a per-slave base/mask address map. Adds unmapped-address and watchdog-timeout bus errors, a sticky error interrupt with captured fault address, and a master-abort path.

## Interface
- NUM_SLAVES, 4: slave port count (1..16)
- WB_DATA_WIDTH, 32: data width
- WB_ADDR_WIDTH, 32: address width
- WB_SEL_WIDTH, 4: byte-select width
- SLAVE_BASE, {NUM_SLAVES{32'h0}}: packed bases; slave i occupies bits [i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]
- SLAVE_MASK, {NUM_SLAVES{32'h0}}: packed masks; slave i matches when (addr & mask_i) == base_i
- TIMEOUT_CYCLES, 255: maximum ACTIVE cycles before timeout; 0 disables the timeout
- ERR_ACKS, 1: 1 = error also pulses wb_m_ack_o with ERR_DATA, for masters without an ERR input
- ERR_DATA, 32'hDEAD_BEEF: read data returned on an error acknowledge

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- wb_m_addr_i / wb_m_data_i / wb_m_sel_i  in  AW / DW / SW  master request
- wb_m_we_i, wb_m_stb_i, wb_m_cyc_i  in  1  master strobes
- wb_m_ack_o, wb_m_err_o  out  1  master responses
- wb_m_data_o  out  DW  master read data
- wb_s_addr_o / wb_s_data_o / wb_s_sel_o  out  AW / DW / SW  broadcast to all slaves
- wb_s_we_o  out  1  broadcast to all slaves
- wb_s_stb_o, wb_s_cyc_o  out  NUM_SLAVES  one-hot, selected slave only
- wb_s_ack_i  in  NUM_SLAVES  per-slave acknowledge
- wb_s_data_i  in  NUM_SLAVES*DW  packed per-slave read data
- err_irq_o  out  1  sticky bus-error interrupt
- err_addr_o  out  AW  address of the last faulting transaction
- clear_err_i  in  1  clears err_irq_o

## Operation
- FSM states IDLE, ACTIVE, ERR.
- **IDLE:**
  - On wb_m_cyc_i & wb_m_stb_i, decode the address. The lowest-index matching slave wins.
  - On a match: latch sel_idx, clear the counter, go to ACTIVE.
  - On no match: go to ERR.
- **ACTIVE:**
  - wb_s_cyc_o[sel_idx] and wb_s_stb_o[sel_idx] are high.
  - wb_m_ack_o = wb_s_ack_i[sel_idx]. wb_m_data_o = the selected slave's data.
  - The counter increments each cycle without an ack.
  - Ack → IDLE.
  - wb_m_cyc_i low → abort: slave strobes drop combinationally, go to IDLE, no error.
  - Counter reaches TIMEOUT_CYCLES−1 without an ack → ERR.
- **ERR (one cycle):**
  - Slave strobes low. wb_m_err_o = 1.
  - If ERR_ACKS, also wb_m_ack_o = 1 and wb_m_data_o = ERR_DATA.
  - Set err_irq_o and capture err_addr_o from the latched request address.
  - Go to IDLE.
- **Address path:** wb_s_addr_o, wb_s_data_o, wb_s_sel_o and wb_s_we_o are driven from registers latched on leaving IDLE. They hold until the next request.
- **Outside ACTIVE:** wb_m_data_o = 0, except on an error acknowledge.
- **Error interrupt:**
  - err_irq_o stays set until clear_err_i.
  - Set and clear in the same cycle: set wins.
  - A second error overwrites err_addr_o.
- **Ack vs timeout:** an ack arriving in the timeout cycle wins; no error is raised.
- **Reset:** forces IDLE from any state. All outputs, sel_idx, counter, err_addr_o and err_irq_o go to 0. In-flight slave strobes drop asynchronously.

## Timing
- Request seen in IDLE at cycle 0 → slave cyc/stb high from cycle 1.
- Slave ack at cycle k → master ack in the same cycle k (combinational pass-through). FSM is IDLE at k+1.
- A new request is accepted in IDLE at k+1 if stb is still high. Masters must drop stb after ack per classic handshake.
- Unmapped address: err at cycle 1.
- Timeout: err at cycle 1+TIMEOUT_CYCLES.
- Back-to-back zero-wait slave: 2 cycles per transfer.

## Structure
- Package wb_pkg: WB_* width constants, state enum (IDLE, ACTIVE, ERR), default ERR_DATA.
- Sub-module wb_addr_match: combinational priority decoder, address → {hit, idx}. Reused by future multi-master arbiters.

## Test plan
- **Mapped read:**
  - Map RAM 0x0/0xFFFF_E000, timer 0x8000_0000/0xFFFF_FFF0.
  - Read 0x8000_0004 with 1-wait timer.
  - → only wb_s_stb_o[1] high at cycles 1–2. Master ack at cycle 2 with timer data. err low.
- **Unmapped write:** write to 0x4000_0000 → err and ack at cycle 1, err_irq_o=1, err_addr_o=0x4000_0000.
- **Timeout:**
  - TIMEOUT_CYCLES=8; slave never acks.
  - → slave stb high for cycles 1–8. err at cycle 9. Slave stb low at 9.
- **Ack in the timeout cycle:** slave acks in cycle 8 with TIMEOUT_CYCLES=8 → ack, no err, err_irq_o unchanged.
- **Abort:**
  - Master drops cyc at cycle 3 mid-ACTIVE.
  - → slave strobes low at cycle 3. IDLE at 4. No err.
  - clear_err_i asserted in the same cycle as a new error → err_irq_o stays 1.
- **Reset mid-transfer:** rst_ni low during ACTIVE → all wb_s_stb_o/wb_s_cyc_o go 0 immediately. After release, IDLE and err_irq_o=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone B4 classic decoder: the default bus widths,
// the decoder FSM state encoding and the default error-acknowledge read data.
package wb_pkg;

    localparam int WB_DW_DEFAULT = 32;
    localparam int WB_AW_DEFAULT = 32;
    localparam int WB_SW_DEFAULT = 4;

    localparam logic [31:0] WB_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_addr_match.sv
// Combinational priority address decoder.
// A slave matches when (addr_i & mask) == base. The lowest-index match wins.
// Ports:
//   addr_i  in   ADDR_WIDTH  address to decode
//   hit_o   out  1           at least one slave matched
//   idx_o   out  IDX_WIDTH   index of the winning slave (0 when no hit)
module wb_addr_match
    import wb_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = WB_AW_DEFAULT,
    parameter int IDX_WIDTH  = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  hit_o,
    output logic [IDX_WIDTH-1:0]  idx_o
);

    // Scan from the top down so that a lower-index match overwrites a higher one.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit_o = 1'b1;
                idx_o = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/wb_decoder_n.sv
// Wishbone B4 classic single-master, N-slave address decoder with unmapped-address
// and watchdog-timeout bus errors, sticky error interrupt and master abort.
//
// state  | meaning
// IDLE   | waiting for cyc&stb; decodes address and latches the request
// ACTIVE | selected slave strobed; ack passes straight through to the master
// ERR    | one-cycle bus error response (err, optionally ack + ERR_DATA)
//
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   wb_m_*_i / wb_m_ack_o, err_o, data_o  master side
//   wb_s_addr_o/data_o/sel_o/we_o         registered request broadcast to all slaves
//   wb_s_stb_o, wb_s_cyc_o                one-hot strobes to the selected slave
//   wb_s_ack_i, wb_s_data_i               per-slave responses (data packed)
//   err_irq_o, err_addr_o, clear_err_i    sticky error interrupt and fault address
module wb_decoder_n
    import wb_pkg::*;
#(
    parameter int NUM_SLAVES     = 4,
    parameter int WB_DATA_WIDTH  = WB_DW_DEFAULT,
    parameter int WB_ADDR_WIDTH  = WB_AW_DEFAULT,
    parameter int WB_SEL_WIDTH   = WB_SW_DEFAULT,
    parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_MASK = '0,
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit ERR_ACKS       = 1'b1,
    parameter logic [WB_DATA_WIDTH-1:0] ERR_DATA = WB_DATA_WIDTH'(WB_ERR_DATA_DEFAULT)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [WB_ADDR_WIDTH-1:0]            wb_m_addr_i,
    input  logic [WB_DATA_WIDTH-1:0]            wb_m_data_i,
    input  logic [WB_SEL_WIDTH-1:0]             wb_m_sel_i,
    input  logic                                wb_m_we_i,
    input  logic                                wb_m_stb_i,
    input  logic                                wb_m_cyc_i,
    output logic                                wb_m_ack_o,
    output logic                                wb_m_err_o,
    output logic [WB_DATA_WIDTH-1:0]            wb_m_data_o,
    output logic [WB_ADDR_WIDTH-1:0]            wb_s_addr_o,
    output logic [WB_DATA_WIDTH-1:0]            wb_s_data_o,
    output logic [WB_SEL_WIDTH-1:0]             wb_s_sel_o,
    output logic                                wb_s_we_o,
    output logic [NUM_SLAVES-1:0]               wb_s_stb_o,
    output logic [NUM_SLAVES-1:0]               wb_s_cyc_o,
    input  logic [NUM_SLAVES-1:0]               wb_s_ack_i,
    input  logic [NUM_SLAVES*WB_DATA_WIDTH-1:0] wb_s_data_i,
    output logic                                err_irq_o,
    output logic [WB_ADDR_WIDTH-1:0]            err_addr_o,
    input  logic                                clear_err_i
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    wb_state_e                state_q, state_d;
    logic [IDX_W-1:0]         sel_idx_q, sel_idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WB_DATA_WIDTH-1:0] data_q, data_d;
    logic [WB_SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                     we_q, we_d;
    logic                     err_irq_q, err_irq_d;
    logic [WB_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    logic                     req;
    logic                     hit;
    logic [IDX_W-1:0]         hit_idx;
    logic                     sel_ack;
    logic [WB_DATA_WIDTH-1:0] sel_data;
    logic [NUM_SLAVES-1:0]    sel_onehot;
    logic [NUM_SLAVES-1:0]    s_strobe;

    assign req = wb_m_cyc_i & wb_m_stb_i;

    wb_addr_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (WB_ADDR_WIDTH),
        .IDX_WIDTH  (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_addr_match (
        .addr_i (wb_m_addr_i),
        .hit_o  (hit),
        .idx_o  (hit_idx)
    );

    always_comb begin
        sel_ack    = 1'b0;
        sel_data   = '0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_idx_q == IDX_W'(i)) begin
                sel_ack       = wb_s_ack_i[i];
                sel_data      = wb_s_data_i[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // Gating on cyc makes a master abort drop the slave strobes in the same cycle.
    assign s_strobe   = (state_q == ST_ACTIVE && wb_m_cyc_i) ? sel_onehot : '0;
    assign wb_s_stb_o = s_strobe;
    assign wb_s_cyc_o = s_strobe;

    always_comb begin
        state_d     = state_q;
        sel_idx_d   = sel_idx_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        sel_d       = sel_q;
        we_d        = we_q;
        err_irq_d   = err_irq_q & ~clear_err_i;
        err_addr_d  = err_addr_q;
        wb_m_ack_o  = 1'b0;
        wb_m_err_o  = 1'b0;
        wb_m_data_o = '0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d = wb_m_addr_i;
                    data_d = wb_m_data_i;
                    sel_d  = wb_m_sel_i;
                    we_d   = wb_m_we_i;
                    if (hit) begin
                        sel_idx_d = hit_idx;
                        cnt_d     = '0;
                        state_d   = ST_ACTIVE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end

            ST_ACTIVE: begin
                wb_m_data_o = sel_data;
                wb_m_ack_o  = sel_ack & wb_m_cyc_i;
                if (!wb_m_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    // An ack in the timeout cycle takes priority over the timeout.
                    state_d = ST_IDLE;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_ERR: begin
                wb_m_err_o = 1'b1;
                if (ERR_ACKS) begin
                    wb_m_ack_o  = 1'b1;
                    wb_m_data_o = ERR_DATA;
                end
                // Setting overrides a simultaneous clear.
                err_irq_d  = 1'b1;
                err_addr_d = addr_q;
                state_d    = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            sel_idx_q  <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            err_irq_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_idx_q  <= sel_idx_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            err_irq_q  <= err_irq_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign wb_s_addr_o = addr_q;
    assign wb_s_data_o = data_q;
    assign wb_s_sel_o  = sel_q;
    assign wb_s_we_o   = we_q;
    assign err_irq_o   = err_irq_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_wb_decoder_n.sv
// Directed bench for wb_decoder_n: mapped read, zero-wait write, unmapped error,
// timeout, ack in the timeout cycle, master abort, set-vs-clear and reset mid-transfer.
module tb_wb_decoder_n;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] wb_m_addr_i = '0;
    logic [31:0] wb_m_data_i = '0;
    logic [3:0]  wb_m_sel_i = '0;
    logic        wb_m_we_i = 1'b0;
    logic        wb_m_stb_i = 1'b0;
    logic        wb_m_cyc_i = 1'b0;
    logic        wb_m_ack_o;
    logic        wb_m_err_o;
    logic [31:0] wb_m_data_o;
    logic [31:0] wb_s_addr_o;
    logic [31:0] wb_s_data_o;
    logic [3:0]  wb_s_sel_o;
    logic        wb_s_we_o;
    logic [3:0]  wb_s_stb_o;
    logic [3:0]  wb_s_cyc_o;
    logic [3:0]  wb_s_ack_i = '0;
    logic [127:0] wb_s_data_i = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    logic        err_irq_o;
    logic [31:0] err_addr_o;
    logic        clear_err_i = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    wb_decoder_n #(
        .NUM_SLAVES     (4),
        .SLAVE_BASE     ({32'h9000_0000, 32'h9000_0000, 32'h8000_0000, 32'h0000_0000}),
        .SLAVE_MASK     ({32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_E000}),
        .TIMEOUT_CYCLES (8),
        .ERR_ACKS       (1'b1),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wb_m_addr_i (wb_m_addr_i),
        .wb_m_data_i (wb_m_data_i),
        .wb_m_sel_i  (wb_m_sel_i),
        .wb_m_we_i   (wb_m_we_i),
        .wb_m_stb_i  (wb_m_stb_i),
        .wb_m_cyc_i  (wb_m_cyc_i),
        .wb_m_ack_o  (wb_m_ack_o),
        .wb_m_err_o  (wb_m_err_o),
        .wb_m_data_o (wb_m_data_o),
        .wb_s_addr_o (wb_s_addr_o),
        .wb_s_data_o (wb_s_data_o),
        .wb_s_sel_o  (wb_s_sel_o),
        .wb_s_we_o   (wb_s_we_o),
        .wb_s_stb_o  (wb_s_stb_o),
        .wb_s_cyc_o  (wb_s_cyc_o),
        .wb_s_ack_i  (wb_s_ack_i),
        .wb_s_data_i (wb_s_data_i),
        .err_irq_o   (err_irq_o),
        .err_addr_o  (err_addr_o),
        .clear_err_i (clear_err_i)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        wb_m_addr_i = a;
        wb_m_we_i   = w;
        wb_m_data_i = d;
        wb_m_sel_i  = s;
        wb_m_cyc_i  = 1'b1;
        wb_m_stb_i  = 1'b1;
    endtask

    task automatic bus_idle();
        wb_m_cyc_i = 1'b0;
        wb_m_stb_i = 1'b0;
        wb_m_we_i  = 1'b0;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_ack", 32'(wb_m_ack_o), 32'd0);
        chk("rst_err", 32'(wb_m_err_o), 32'd0);
        chk("rst_stb", 32'(wb_s_stb_o), 32'd0);
        chk("rst_irq", 32'(err_irq_o), 32'd0);
        chk("rst_eaddr", err_addr_o, 32'd0);
        rst_ni = 1'b1;
        step();

        // mapped read, 1-wait timer
        req(32'h8000_0004, 1'b0, 32'h0, 4'hF);
        #1 chk("rd_c0_stb", 32'(wb_s_stb_o), 32'h0);
        step(); #1;
        chk("rd_c1_stb", 32'(wb_s_stb_o), 32'h2);
        chk("rd_c1_cyc", 32'(wb_s_cyc_o), 32'h2);
        chk("rd_c1_ack", 32'(wb_m_ack_o), 32'd0);
        chk("rd_c1_addr", wb_s_addr_o, 32'h8000_0004);
        step(); wb_s_ack_i = 4'b0010; #1;
        chk("rd_c2_stb", 32'(wb_s_stb_o), 32'h2);
        chk("rd_c2_ack", 32'(wb_m_ack_o), 32'd1);
        chk("rd_c2_data", wb_m_data_o, 32'hD1D1_0001);
        chk("rd_c2_err", 32'(wb_m_err_o), 32'd0);
        step(); wb_s_ack_i = '0; bus_idle(); #1;
        chk("rd_c3_stb", 32'(wb_s_stb_o), 32'h0);
        chk("rd_c3_data", wb_m_data_o, 32'h0);

        // zero-wait write to RAM
        req(32'h0000_1000, 1'b1, 32'hCAFE_F00D, 4'b0011);
        step(); wb_s_ack_i = 4'b0001; #1;
        chk("wr_ack", 32'(wb_m_ack_o), 32'd1);
        chk("wr_stb", 32'(wb_s_stb_o), 32'h1);
        chk("wr_we", 32'(wb_s_we_o), 32'd1);
        chk("wr_sdata", wb_s_data_o, 32'hCAFE_F00D);
        chk("wr_ssel", 32'(wb_s_sel_o), 32'h3);
        step(); wb_s_ack_i = '0; bus_idle(); #1;
        chk("wr_done_stb", 32'(wb_s_stb_o), 32'h0);

        // unmapped write
        req(32'h4000_0000, 1'b1, 32'h55, 4'hF);
        step(); #1;
        chk("um_err", 32'(wb_m_err_o), 32'd1);
        chk("um_ack", 32'(wb_m_ack_o), 32'd1);
        chk("um_data", wb_m_data_o, 32'hDEAD_BEEF);
        chk("um_stb", 32'(wb_s_stb_o), 32'h0);
        step(); bus_idle(); #1;
        chk("um_err_c2", 32'(wb_m_err_o), 32'd0);
        chk("um_irq", 32'(err_irq_o), 32'd1);
        chk("um_eaddr", err_addr_o, 32'h4000_0000);
        clear_err_i = 1'b1;
        step(); clear_err_i = 1'b0; #1;
        chk("clr_irq", 32'(err_irq_o), 32'd0);

        // timeout: slave 2 never acks (also slave 3 matches; lowest index wins)
        req(32'h9000_1234, 1'b0, 32'h0, 4'hF);
        for (int i = 1; i <= 8; i++) begin
            step(); #1;
            chk($sformatf("to_c%0d_stb", i), 32'(wb_s_stb_o), 32'h4);
            chk($sformatf("to_c%0d_err", i), 32'(wb_m_err_o), 32'd0);
        end
        step(); #1;
        chk("to_c9_err", 32'(wb_m_err_o), 32'd1);
        chk("to_c9_ack", 32'(wb_m_ack_o), 32'd1);
        chk("to_c9_stb", 32'(wb_s_stb_o), 32'h0);
        step(); bus_idle(); #1;
        chk("to_irq", 32'(err_irq_o), 32'd1);
        chk("to_eaddr", err_addr_o, 32'h9000_1234);

        // ack in the timeout cycle, slave 3
        req(32'h90AB_0000, 1'b0, 32'h0, 4'hF);
        for (int i = 1; i <= 7; i++) step();
        step(); wb_s_ack_i = 4'b1000; #1;
        chk("at_stb", 32'(wb_s_stb_o), 32'h8);
        chk("at_ack", 32'(wb_m_ack_o), 32'd1);
        chk("at_err", 32'(wb_m_err_o), 32'd0);
        chk("at_data", wb_m_data_o, 32'hD3D3_0003);
        step(); wb_s_ack_i = '0; bus_idle(); #1;
        chk("at_c9_err", 32'(wb_m_err_o), 32'd0);
        chk("at_c9_irq", 32'(err_irq_o), 32'd1);
        chk("at_c9_eaddr", err_addr_o, 32'h9000_1234);
        step(); #1;
        chk("at_c10_err", 32'(wb_m_err_o), 32'd0);

        // master abort, then unmapped error with simultaneous clear
        req(32'h0000_0100, 1'b0, 32'h0, 4'hF);
        step(); step(); #1;
        chk("ab_c2_stb", 32'(wb_s_stb_o), 32'h1);
        step(); bus_idle(); #1;
        chk("ab_c3_stb", 32'(wb_s_stb_o), 32'h0);
        chk("ab_c3_cyc", 32'(wb_s_cyc_o), 32'h0);
        chk("ab_c3_err", 32'(wb_m_err_o), 32'd0);
        step(); req(32'h4000_0010, 1'b0, 32'h0, 4'hF); #1;
        chk("ab_c4_err", 32'(wb_m_err_o), 32'd0);
        step(); clear_err_i = 1'b1; #1;
        chk("ab_c5_err", 32'(wb_m_err_o), 32'd1);
        step(); clear_err_i = 1'b0; bus_idle(); #1;
        chk("sc_irq", 32'(err_irq_o), 32'd1);
        chk("sc_eaddr", err_addr_o, 32'h4000_0010);

        // reset mid-transfer
        req(32'h8000_0004, 1'b0, 32'h0, 4'hF);
        step(); #1;
        chk("rm_c1_stb", 32'(wb_s_stb_o), 32'h2);
        rst_ni = 1'b0; #1;
        chk("rm_stb", 32'(wb_s_stb_o), 32'h0);
        chk("rm_cyc", 32'(wb_s_cyc_o), 32'h0);
        bus_idle();
        #3 rst_ni = 1'b1;
        step(); #1;
        chk("rm_irq", 32'(err_irq_o), 32'd0);
        chk("rm_eaddr", err_addr_o, 32'h0);
        chk("rm_saddr", wb_s_addr_o, 32'h0);
        chk("rm_stb2", 32'(wb_s_stb_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
